// File: rtl/litepcie_usp_pkg.sv
// Shared types and helpers for the UltraScale+ RC adapter.
// Optional feature macro used by the adapter: LITEPCIE_RC_ERR_COUNT_EN.
package litepcie_usp_pkg;

  localparam int unsigned RC_DATA_W    = 256;
  localparam int unsigned RC_DKEEP_W   = RC_DATA_W / 32;
  localparam int unsigned RC_TUSER_A_W = 75;
  localparam int unsigned RC_DISC_BIT  = 42;
  localparam int unsigned RC_HDR_W     = 96;

  // Completion fmt/type bytes
  localparam logic [7:0] FMT_CPL    = 8'h0A;
  localparam logic [7:0] FMT_CPLD   = 8'h4A;
  localparam logic [7:0] FMT_CPLLK  = 8'h0B;
  localparam logic [7:0] FMT_CPLDLK = 8'h4B;

  // RC descriptor field offsets within DW0-2 of the first beat
  localparam int unsigned DESC_LA_LSB     = 0;
  localparam int unsigned DESC_BC_LSB     = 16;
  localparam int unsigned DESC_LOCKED_BIT = 29;
  localparam int unsigned DESC_DWCNT_LSB  = 32;
  localparam int unsigned DESC_STATUS_LSB = 43;
  localparam int unsigned DESC_POISON_BIT = 46;
  localparam int unsigned DESC_REQID_LSB  = 48;
  localparam int unsigned DESC_TAG_LSB    = 64;
  localparam int unsigned DESC_CPLID_LSB  = 72;
  localparam int unsigned DESC_TC_LSB     = 89;
  localparam int unsigned DESC_ATTR_LSB   = 92;

  typedef struct packed {
    logic [15:0] cpl_id;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic        poison;
    logic [2:0]  status;
    logic [10:0] dwcnt;
    logic        locked;
    logic [12:0] byte_count;
    logic [6:0]  lower_addr;
  } rc_desc_t;

  // One buffered beat; dword keep is expanded on the way out
  typedef struct packed {
    logic                  disc;
    logic                  last;
    logic [RC_DKEEP_W-1:0] dkeep;
    logic [RC_DATA_W-1:0]  data;
  } rc_beat_t;

  // Pull the descriptor fields out of DW0-2
  function automatic rc_desc_t rc_desc_unpack(input logic [RC_HDR_W-1:0] d);
    rc_desc_t x;
    x.lower_addr = d[DESC_LA_LSB +: 7];
    x.byte_count = d[DESC_BC_LSB +: 13];
    x.locked     = d[DESC_LOCKED_BIT];
    x.dwcnt      = d[DESC_DWCNT_LSB +: 11];
    x.status     = d[DESC_STATUS_LSB +: 3];
    x.poison     = d[DESC_POISON_BIT];
    x.req_id     = d[DESC_REQID_LSB +: 16];
    x.tag        = d[DESC_TAG_LSB +: 8];
    x.cpl_id     = d[DESC_CPLID_LSB +: 16];
    x.tc         = d[DESC_TC_LSB +: 3];
    x.attr       = d[DESC_ATTR_LSB +: 3];
    return x;
  endfunction

  // Build the 3-DW completion header; upper bits drop to give the PCIe wrap encoding
  function automatic logic [RC_HDR_W-1:0] cpl_hdr_build(input rc_desc_t x);
    logic [7:0]  fmt;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    if (x.locked) fmt = (x.dwcnt != 11'd0) ? FMT_CPLDLK : FMT_CPLLK;
    else          fmt = (x.dwcnt != 11'd0) ? FMT_CPLD   : FMT_CPL;
    dw0 = {fmt, 1'b0, x.tc, 5'b0, x.poison, x.attr[1:0], 2'b0, x.dwcnt[9:0]};
    dw1 = {x.cpl_id, x.status, 1'b0, x.byte_count[11:0]};
    dw2 = {x.req_id, x.tag, 1'b0, x.lower_addr};
    return {dw2, dw1, dw0};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered data, valid and upstream ready.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             user_clk,
  input  logic             user_reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data_q;
  logic [WIDTH-1:0] skid_data_d;
  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [WIDTH-1:0] out_data_d;
  logic             out_valid_d;
  logic             in_fire_c;
  logic             out_load_c;

  // Next-state: output register loads from skid first, otherwise from the input
  always_comb begin
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    in_fire_c    = in_valid & in_ready;
    out_load_c   = ~out_valid | out_ready;
    if (out_load_c) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire_c;
        if (in_fire_c) out_data_d = in_data;
      end
    end else if (in_fire_c) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; ready mirrors an empty skid entry
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      out_data     <= out_data_d;
      out_valid    <= out_valid_d;
      in_ready     <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/m_axis_rc_adapt_reg.sv
// RC receive adapter: hard-IP RC descriptor -> PCIe completion header, dword->byte keep,
// registered through a 2-entry skid buffer.
// Optional: LITEPCIE_RC_ERR_COUNT_EN adds rc_err_count (errored completions, saturating).
module m_axis_rc_adapt_reg
  import litepcie_usp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    user_clk,
  input  logic                    user_reset_n,
  input  logic [DATA_WIDTH-1:0]   m_axis_rc_tdata_a,
  input  logic [KEEP_WIDTH/4-1:0] m_axis_rc_tkeep_a,
  input  logic                    m_axis_rc_tlast_a,
  input  logic [RC_TUSER_A_W-1:0] m_axis_rc_tuser_a,
  input  logic                    m_axis_rc_tvalid_a,
  output logic                    m_axis_rc_tready_a,
  output logic [DATA_WIDTH-1:0]   m_axis_rc_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_rc_tkeep,
  output logic                    m_axis_rc_tlast,
  output logic [3:0]              m_axis_rc_tuser,
  output logic                    m_axis_rc_tvalid,
  input  logic                    m_axis_rc_tready
`ifdef LITEPCIE_RC_ERR_COUNT_EN
  ,
  output logic [15:0]             rc_err_count
`endif
);

  logic     first_q;
  logic     in_fire_c;
  rc_desc_t desc_c;
  rc_beat_t in_beat_c;
  rc_beat_t out_beat;
  logic     unused_tuser_c;

  assign in_fire_c      = m_axis_rc_tvalid_a & m_axis_rc_tready_a;
  assign desc_c         = rc_desc_unpack(m_axis_rc_tdata_a[RC_HDR_W-1:0]);
  assign unused_tuser_c = ^{m_axis_rc_tuser_a[RC_TUSER_A_W-1:RC_DISC_BIT+1],
                            m_axis_rc_tuser_a[RC_DISC_BIT-1:0]};

  // Header substitution on the first beat of each completion
  always_comb begin
    in_beat_c       = '0;
    in_beat_c.data  = m_axis_rc_tdata_a;
    in_beat_c.dkeep = m_axis_rc_tkeep_a;
    in_beat_c.last  = m_axis_rc_tlast_a;
    in_beat_c.disc  = m_axis_rc_tuser_a[RC_DISC_BIT];
    if (first_q) in_beat_c.data[RC_HDR_W-1:0] = cpl_hdr_build(desc_c);
  end

  // Tracks whether the next accepted beat starts a completion
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n)  first_q <= 1'b1;
    else if (in_fire_c) first_q <= m_axis_rc_tlast_a;
  end

  axis_skid_buf #(
    .WIDTH($bits(rc_beat_t))
  ) u_skid (
    .user_clk    (user_clk),
    .user_reset_n(user_reset_n),
    .in_data     (in_beat_c),
    .in_valid    (m_axis_rc_tvalid_a),
    .in_ready    (m_axis_rc_tready_a),
    .out_data    (out_beat),
    .out_valid   (m_axis_rc_tvalid),
    .out_ready   (m_axis_rc_tready)
  );

  assign m_axis_rc_tdata = out_beat.data;
  assign m_axis_rc_tlast = out_beat.last;
  assign m_axis_rc_tuser = {3'b000, out_beat.disc};

  // Each dword keep bit covers four byte lanes
  for (genvar g = 0; g < KEEP_WIDTH; g++) begin : g_keep
    assign m_axis_rc_tkeep[g] = out_beat.dkeep[g/4];
  end

`ifdef LITEPCIE_RC_ERR_COUNT_EN
  logic [15:0] err_cnt_q;
  logic        err_hit_c;

  assign err_hit_c = in_fire_c & first_q &
                     ((desc_c.status != 3'd0) | desc_c.poison | m_axis_rc_tuser_a[RC_DISC_BIT]);

  // Saturating count of errored completions
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n)                             err_cnt_q <= 16'd0;
    else if (err_hit_c && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign rc_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_m_axis_rc_adapt_reg.sv
// Scoreboard bench for m_axis_rc_adapt_reg (optionally with LITEPCIE_RC_ERR_COUNT_EN).
`timescale 1ns/1ps
module tb_m_axis_rc_adapt_reg;

  logic         user_clk = 1'b0;
  logic         user_reset_n = 1'b1;
  logic [255:0] m_axis_rc_tdata_a = '0;
  logic [7:0]   m_axis_rc_tkeep_a = '0;
  logic         m_axis_rc_tlast_a = 1'b0;
  logic [74:0]  m_axis_rc_tuser_a = '0;
  logic         m_axis_rc_tvalid_a = 1'b0;
  logic         m_axis_rc_tready_a;
  logic [255:0] m_axis_rc_tdata;
  logic [31:0]  m_axis_rc_tkeep;
  logic         m_axis_rc_tlast;
  logic [3:0]   m_axis_rc_tuser;
  logic         m_axis_rc_tvalid;
  logic         m_axis_rc_tready = 1'b1;
`ifdef LITEPCIE_RC_ERR_COUNT_EN
  logic [15:0]  rc_err_count;
`endif

  m_axis_rc_adapt_reg dut (
    .user_clk          (user_clk),
    .user_reset_n      (user_reset_n),
    .m_axis_rc_tdata_a (m_axis_rc_tdata_a),
    .m_axis_rc_tkeep_a (m_axis_rc_tkeep_a),
    .m_axis_rc_tlast_a (m_axis_rc_tlast_a),
    .m_axis_rc_tuser_a (m_axis_rc_tuser_a),
    .m_axis_rc_tvalid_a(m_axis_rc_tvalid_a),
    .m_axis_rc_tready_a(m_axis_rc_tready_a),
    .m_axis_rc_tdata   (m_axis_rc_tdata),
    .m_axis_rc_tkeep   (m_axis_rc_tkeep),
    .m_axis_rc_tlast   (m_axis_rc_tlast),
    .m_axis_rc_tuser   (m_axis_rc_tuser),
    .m_axis_rc_tvalid  (m_axis_rc_tvalid),
    .m_axis_rc_tready  (m_axis_rc_tready)
`ifdef LITEPCIE_RC_ERR_COUNT_EN
    ,
    .rc_err_count      (rc_err_count)
`endif
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [3:0]   u;
  } exp_t;

  typedef struct {
    int unsigned dwcnt, bc, la, status, req_id, tag, cpl_id, tc, attr;
    bit          locked, poison, disc;
  } cpl_t;

  exp_t        sb_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned exp_err = 0;
  int unsigned n_out = 0;
  int          out_mode = 0;
  bit          saw_stall = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] expand_keep(input logic [7:0] dk);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (((dk >> i) & 8'd1) != 8'd0) r = r | (32'hF << (4 * i));
    return r;
  endfunction

  // Completion header from the PCIe field definitions
  function automatic logic [95:0] model_hdr(input cpl_t c);
    int unsigned fmt;
    logic [31:0] dw0, dw1, dw2;
    fmt = (c.dwcnt != 0) ? 32'h4A : 32'h0A;
    if (c.locked) fmt = fmt + 1;
    dw0 = (fmt << 24) | ((c.tc % 8) << 20) | (32'(c.poison) << 14) |
          ((c.attr % 4) << 12) | (c.dwcnt % 1024);
    dw1 = (c.cpl_id << 16) | (c.status << 13) | (c.bc % 4096);
    dw2 = (c.req_id << 16) | (c.tag << 8) | (c.la % 128);
    return {dw2, dw1, dw0};
  endfunction

  // Hard-IP descriptor with random filler in the unused bits
  function automatic logic [255:0] make_desc(input cpl_t c);
    logic [255:0] d;
    d = rand256();
    d[6:0]   = 7'(c.la);
    d[28:16] = 13'(c.bc);
    d[29]    = c.locked;
    d[42:32] = 11'(c.dwcnt);
    d[45:43] = 3'(c.status);
    d[46]    = c.poison;
    d[63:48] = 16'(c.req_id);
    d[71:64] = 8'(c.tag);
    d[87:72] = 16'(c.cpl_id);
    d[91:89] = 3'(c.tc);
    d[94:92] = 3'(c.attr);
    return d;
  endfunction

  function automatic cpl_t rand_cpl();
    cpl_t c;
    c.dwcnt  = $urandom_range(0, 1024);
    c.bc     = $urandom_range(0, 4096);
    c.la     = $urandom_range(0, 127);
    c.status = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
    c.req_id = $urandom_range(0, 65535);
    c.tag    = $urandom_range(0, 255);
    c.cpl_id = $urandom_range(0, 65535);
    c.tc     = $urandom_range(0, 7);
    c.attr   = $urandom_range(0, 7);
    c.locked = ($urandom_range(0, 3) == 0);
    c.poison = ($urandom_range(0, 7) == 0);
    c.disc   = ($urandom_range(0, 7) == 0);
    return c;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic drive_beat(input logic [255:0] d, input logic [7:0] dk, input logic last,
                            input logic disc, input logic [255:0] exp_d, output bit ok);
    logic [74:0] tu;
    exp_t e;
    tu = 75'({$urandom, $urandom, $urandom});
    tu[42] = disc;
    m_axis_rc_tdata_a  = d;
    m_axis_rc_tkeep_a  = dk;
    m_axis_rc_tlast_a  = last;
    m_axis_rc_tuser_a  = tu;
    m_axis_rc_tvalid_a = 1'b1;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge user_clk);
      if (m_axis_rc_tready_a) begin
        e.d = exp_d; e.k = expand_keep(dk); e.l = last; e.u = {3'b000, disc};
        sb_q.push_back(e);
        ok = 1;
        @(posedge user_clk); #1;
        break;
      end
      saw_stall = 1;
      @(posedge user_clk); #1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: tready_a stayed %b, required 1", m_axis_rc_tready_a);
    end
  endtask

  task automatic send_pkt(input cpl_t c, input int nb, input logic [7:0] last_keep, input int max_gap);
    logic [255:0] d, exp_d;
    bit ok;
    int gap;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) begin
        d = make_desc(c);
        exp_d = {d[255:96], model_hdr(c)};
      end else begin
        d = rand256();
        exp_d = d;
      end
      drive_beat(d, (b == nb - 1) ? last_keep : 8'hFF, (b == nb - 1),
                 (b == 0) ? c.disc : 1'b0, exp_d, ok);
      if (b == 0 && ok && (c.status != 0 || c.poison || c.disc)) exp_err++;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (gap > 0) begin
        m_axis_rc_tvalid_a = 1'b0;
        repeat (gap) @(posedge user_clk);
        #1;
      end
    end
    m_axis_rc_tvalid_a = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge user_clk);
      t++;
    end
    #1;
    chk("drain_empty", 256'(sb_q.size()), 256'd0);
  endtask

  // Returns at posedge+1 with tready_a already high
  task automatic do_reset();
    m_axis_rc_tvalid_a = 1'b0;
    user_reset_n = 1'b0;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk("rst_tvalid", 256'(m_axis_rc_tvalid), 256'd0);
    chk("rst_tready_a", 256'(m_axis_rc_tready_a), 256'd0);
    sb_q.delete();
    exp_err = 0;
    @(posedge user_clk); #1;
    user_reset_n = 1'b1;
    @(negedge user_clk);
    chk("tready_a_before_edge", 256'(m_axis_rc_tready_a), 256'd0);
    @(posedge user_clk); #1;
    chk("tready_a_rise", 256'(m_axis_rc_tready_a), 256'd1);
  endtask

  // User-side ready pattern
  initial begin
    forever begin
      @(posedge user_clk); #1;
      case (out_mode)
        0:       m_axis_rc_tready = 1'b1;
        1:       m_axis_rc_tready = ~m_axis_rc_tready;
        default: m_axis_rc_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare each transferred beat with the scoreboard head, and check stall stability
  bit           hold_v = 0;
  logic [255:0] hold_d;
  exp_t         mon_e;
  always @(negedge user_clk) begin
    if (!user_reset_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("stall_tvalid", 256'(m_axis_rc_tvalid), 256'd1);
        chk("stall_tdata", m_axis_rc_tdata, hold_d);
      end
      hold_v = m_axis_rc_tvalid && !m_axis_rc_tready;
      hold_d = m_axis_rc_tdata;
      if (m_axis_rc_tvalid && m_axis_rc_tready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got tdata %h with nothing expected", m_axis_rc_tdata);
        end else begin
          mon_e = sb_q.pop_front();
          chk("tdata", m_axis_rc_tdata, mon_e.d);
          chk("tkeep", 256'(m_axis_rc_tkeep), 256'(mon_e.k));
          chk("tlast", 256'(m_axis_rc_tlast), 256'(mon_e.l));
          chk("tuser", 256'(m_axis_rc_tuser), 256'(mon_e.u));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    cpl_t c;
    int unsigned n0;
    logic [255:0] d;
    bit ok;

    #2;
    do_reset();

    // Single-beat CplD with 1-cycle latency
    out_mode = 0;
    c = '{dwcnt: 4, bc: 16, la: 'h10, status: 0, req_id: 'h1234, tag: 'h2A, cpl_id: 'h0100,
          tc: 0, attr: 0, locked: 0, poison: 0, disc: 0};
    send_pkt(c, 1, 8'h7F, 0);
    chk("latency_tvalid", 256'(m_axis_rc_tvalid), 256'd1);
    drain();

    // Multi-beat CplD with toggling user ready
    out_mode = 1;
    saw_stall = 0;
    n0 = n_out;
    c = '{dwcnt: 32, bc: 128, la: 'h40, status: 0, req_id: 'hBEEF, tag: 'h11, cpl_id: 'h0200,
          tc: 5, attr: 6, locked: 0, poison: 0, disc: 0};
    send_pkt(c, 5, 8'h07, 0);
    drain();
    chk("multi_beats_out", 256'(n_out - n0), 256'd5);
    chk("tready_a_deassert", 256'(saw_stall), 256'd1);

    // Zero-data, locked, and wrap-encoding variants back to back
    out_mode = 0;
    c = '{dwcnt: 0, bc: 0, la: 3, status: 0, req_id: 7, tag: 1, cpl_id: 9,
          tc: 1, attr: 1, locked: 0, poison: 0, disc: 0};
    send_pkt(c, 1, 8'h07, 0);
    c.locked = 1; c.dwcnt = 1; c.bc = 4;
    send_pkt(c, 1, 8'h0F, 0);
    c.locked = 0; c.dwcnt = 1024; c.bc = 4096; c.la = 0;
    send_pkt(c, 2, 8'hFF, 0);
    drain();

    // Reset mid-packet, then a fresh completion
    out_mode = 2;
    c = rand_cpl();
    d = make_desc(c);
    drive_beat(d, 8'hFF, 1'b0, c.disc, {d[255:96], model_hdr(c)}, ok);
    d = rand256();
    drive_beat(d, 8'hFF, 1'b0, 1'b0, d, ok);
    m_axis_rc_tvalid_a = 1'b0;
    do_reset();
    c = '{dwcnt: 8, bc: 32, la: 'h20, status: 0, req_id: 'hCAFE, tag: 'h55, cpl_id: 'h0300,
          tc: 2, attr: 2, locked: 0, poison: 0, disc: 0};
    send_pkt(c, 2, 8'h1F, 0);
    drain();

    // Three errored completions
    c.status = 1;
    send_pkt(c, 1, 8'h0F, 0);
    c.status = 0; c.poison = 1;
    send_pkt(c, 1, 8'h0F, 0);
    c.poison = 0; c.disc = 1;
    send_pkt(c, 1, 8'h0F, 0);
    drain();
`ifdef LITEPCIE_RC_ERR_COUNT_EN
    chk("err_count_3", 256'(rc_err_count), 256'(exp_err));
    chk("err_count_model", 256'(exp_err), 256'd3);
`endif

    // Randomized traffic
    for (int p = 0; p < 250; p++) begin
      if ((p % 50) == 0) out_mode = $urandom_range(0, 2);
      send_pkt(rand_cpl(), $urandom_range(1, 4), 8'($urandom_range(1, 255)), $urandom_range(0, 2));
    end
    drain();
`ifdef LITEPCIE_RC_ERR_COUNT_EN
    chk("err_count_final", 256'(rc_err_count), 256'(exp_err));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
